seq_mag_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands MSB-first, SLICE bits per clock, with a start/done handshake.
- Successor to the fixed 8-bit chained comparator. Adds generic width, signed mode, early termination and a registered three-way result (eq/gt/lt).
- Sits between switch/register sources and LED/status logic on the 100 MHz board clock.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_slice.sv | 14 +
 rtl/seq_mag_comparator.sv | 132 +++++++++++++
 tb/tb_seq_mag_comparator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational per-slice compare cell: equality and unsigned greater-than.
module cmp_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] slice_a,
  input  logic [SLICE-1:0] slice_b,
  output logic             slice_eq,
  output logic             slice_gt
);

  assign slice_eq = (slice_a == slice_b);
  assign slice_gt = (slice_a > slice_b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with start/done handshake and
// registered three-way result.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 2,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  // Flipping the sign bit maps two's complement onto offset binary.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  if (SLICE < 1 || SLICE > WIDTH) begin : g_bad_slice
    $error("seq_mag_comparator: SLICE must be in 1..WIDTH");
  end else if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("seq_mag_comparator: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             dec_gt_q, dec_gt_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic slice_eq, slice_gt;
  logic final_dec, final_gt;

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .slice_a  (a_q[WIDTH-1 -: SLICE]),
    .slice_b  (b_q[WIDTH-1 -: SLICE]),
    .slice_eq (slice_eq),
    .slice_gt (slice_gt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dec_gt_d  = dec_gt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    final_dec = decided_q | ~slice_eq;
    final_gt  = decided_q ? dec_gt_q : slice_gt;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a ^ SIGN_MASK;
          b_d       = b ^ SIGN_MASK;
          cnt_d     = '0;
          decided_d = 1'b0;
          dec_gt_d  = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Only the first differing slice decides the ordering.
        if (!slice_eq && !decided_q) begin
          decided_d = 1'b1;
          dec_gt_d  = slice_gt;
        end
        if ((!slice_eq && EARLY_EXIT != 0) || cnt_q == LAST_CNT) begin
          state_d = DONE;
          eq_d    = ~final_dec;
          gt_d    = final_dec & final_gt;
          lt_d    = final_dec & ~final_gt;
        end else begin
          a_d   = a_q << SLICE;
          b_d   = b_q << SLICE;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dec_gt_q  <= dec_gt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: four configurations driven with
// directed and random operands, checked against an arithmetic reference.
module tb_seq_mag_comparator;

  localparam int W  = 16;
  localparam int NI = 4;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         start_v [NI];
  logic [W-1:0] a_v     [NI];
  logic [W-1:0] b_v     [NI];
  logic         busy_v  [NI];
  logic         done_v  [NI];
  logic         eq_v    [NI];
  logic         gt_v    [NI];
  logic         lt_v    [NI];

  exp_t       exp_q [NI][$];
  int         free_cyc   [NI];
  int         clear_cyc  [NI];
  int         busy_from  [NI];
  int         busy_until [NI];
  logic [2:0] cur_res    [NI];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: unsigned early-exit, 1: unsigned full-latency,
  // 2: signed early-exit, 3: signed one-shot (SLICE = WIDTH).
  seq_mag_comparator #(.WIDTH(W), .SLICE(2), .SIGNED(0), .EARLY_EXIT(1)) u_dut0 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0]));
  seq_mag_comparator #(.WIDTH(W), .SLICE(2), .SIGNED(0), .EARLY_EXIT(0)) u_dut1 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1]));
  seq_mag_comparator #(.WIDTH(W), .SLICE(2), .SIGNED(1), .EARLY_EXIT(1)) u_dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .gt(gt_v[2]), .lt(lt_v[2]));
  seq_mag_comparator #(.WIDTH(W), .SLICE(16), .SIGNED(1), .EARLY_EXIT(1)) u_dut3 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .eq(eq_v[3]), .gt(gt_v[3]), .lt(lt_v[3]));

  task automatic check_output(input string name, input int i,
                              input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d cyc %0d: got %0h, expected %0h",
               name, i, cyc, got, exp);
    end
  endtask

  // Result from plain integer comparison; done_cyc carries the RUN length.
  function automatic exp_t ref_model(input int i, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    exp_t   r;
    int     sl, ns, sh;
    bit     sg, ee;
    longint av, bv;
    sl = (i == 3) ? 16 : 2;
    sg = (i == 2 || i == 3);
    ee = (i != 1);
    ns = W / sl;
    av = sg ? longint'($signed(a)) : longint'(a);
    bv = sg ? longint'($signed(b)) : longint'(b);
    r.eq = (av == bv);
    r.gt = (av > bv);
    r.lt = (av < bv);
    r.done_cyc = ns;
    if (ee && a != b) begin
      for (int k = 0; k < ns; k++) begin
        sh = W - sl * (k + 1);
        if (((int'(a) >> sh) & ((1 << sl) - 1)) != ((int'(b) >> sh) & ((1 << sl) - 1))) begin
          r.done_cyc = k + 1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick_b(input logic [W-1:0] a);
    case ($urandom_range(0, 3))
      0:       return a;
      1:       return a ^ W'(1 << $urandom_range(0, W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  // Called at a negedge when the reference says the instance is idle.
  task automatic apply_stimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    r = ref_model(i, a, b);
    a_v[i]     = a;
    b_v[i]     = b;
    start_v[i] = 1'b1;
    r.done_cyc = cyc + 1 + r.done_cyc;
    exp_q[i].push_back(r);
    clear_cyc[i]  = cyc + 1;
    busy_from[i]  = cyc + 1;
    busy_until[i] = r.done_cyc;
    free_cyc[i]   = r.done_cyc + 1;
  endtask

  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    while (cyc < free_cyc[i]) @(negedge clk);
    apply_stimulus(i, a, b);
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = W'($urandom);
    b_v[i] = W'($urandom);
  endtask

  task automatic poke(input int i);
    @(negedge clk);
    if (cyc < free_cyc[i]) begin
      start_v[i] = 1'b1;
      a_v[i] = W'($urandom);
      b_v[i] = W'($urandom);
      @(negedge clk);
      start_v[i] = 1'b0;
    end
  endtask

  task automatic hold_start(input int i, input int n);
    int cnt = 0;
    logic [W-1:0] ra;
    for (int it = 0; it < 500 && cnt < n; it++) begin
      @(negedge clk);
      ra = W'($urandom);
      if (cyc >= free_cyc[i]) begin
        apply_stimulus(i, ra, pick_b(ra));
        cnt++;
      end else begin
        start_v[i] = 1'b1;
        a_v[i] = ra;
        b_v[i] = W'($urandom);
      end
    end
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic rand_ops(input int i, input int n);
    logic [W-1:0] ra;
    for (int k = 0; k < n; k++) begin
      ra = W'($urandom);
      run_op(i, ra, pick_b(ra));
      if ($urandom_range(0, 3) == 0) poke(i);
    end
  endtask

  // Monitor: pops the scoreboard on each expected done and checks held outputs.
  always @(negedge clk) begin
    exp_t r;
    bit   due;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        cur_res[i] = 3'b000;
        check_output("rst_done", i, done_v[i], 0);
        check_output("rst_busy", i, busy_v[i], 0);
        check_output("rst_result", i, {eq_v[i], gt_v[i], lt_v[i]}, 0);
      end else begin
        if (cyc == clear_cyc[i]) cur_res[i] = 3'b000;
        due = (exp_q[i].size() > 0) && (exp_q[i][0].done_cyc == cyc);
        check_output("done", i, done_v[i], due);
        if (due) begin
          r = exp_q[i].pop_front();
          cur_res[i] = {r.eq, r.gt, r.lt};
        end
        check_output("result", i, {eq_v[i], gt_v[i], lt_v[i]}, cur_res[i]);
        check_output("busy", i, busy_v[i], (cyc >= busy_from[i] && cyc <= busy_until[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      free_cyc[i] = 0;
      clear_cyc[i] = -1;
      busy_from[i] = 1;
      busy_until[i] = 0;
      cur_res[i] = 3'b000;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check_output("reset_state", i, {busy_v[i], done_v[i], eq_v[i], gt_v[i], lt_v[i]}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'h1234, 16'h1234);
    run_op(0, 16'h8000, 16'h7FFF);
    run_op(0, 16'h0001, 16'h0002);
    run_op(0, 16'hFFFE, 16'hFFFD);
    run_op(1, 16'h8000, 16'h7FFF);
    run_op(1, 16'h1234, 16'h1234);
    run_op(2, 16'h8000, 16'h0001);
    run_op(2, 16'hFFFF, 16'hFFFE);
    run_op(3, 16'h8000, 16'h0001);
    run_op(3, 16'h7FFF, 16'hFFFF);
    run_op(3, 16'h1234, 16'h1234);

    // Starts during RUN and during the DONE cycle must be dropped.
    run_op(0, 16'h1234, 16'h1234);
    @(negedge clk);
    poke(0);
    while (cyc < free_cyc[0] - 2) @(negedge clk);
    poke(0);

    hold_start(0, 4);
    hold_start(2, 3);
    hold_start(1, 2);

    // Asynchronous reset in the middle of an equal-operand compare.
    run_op(0, 16'h1234, 16'h1234);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_output("async_reset", i, {busy_v[i], done_v[i], eq_v[i], gt_v[i], lt_v[i]}, 0);
      start_v[i] = 1'b0;
      free_cyc[i] = 0;
      clear_cyc[i] = -1;
      busy_from[i] = 1;
      busy_until[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_op(0, 16'h1234, 16'h1234);
    run_op(0, 16'h0010, 16'h0020);

    fork
      rand_ops(0, 40);
      rand_ops(1, 40);
      rand_ops(2, 40);
      rand_ops(3, 40);
    join

    repeat (30) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check_output("drain", i, exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
